cmd_processor_nm: RTL
=====================

# cmd_processor_nm

Parametrised command processor that turns board-level user input (switch word plus load/start buttons) into serial commands for one of N bus masters on the system bus. It generalises the two-master, fixed 8-bit command processor: data width, lane width, master count, debounce length and ack timeout are parameters. It adds a per-master ack/read-return handshake with timeout and error reporting. It sits between the board I/O wrapper and the master ports of the system bus.

## Interface

- DATA_WIDTH, 8, command word width; must be a multiple of LANE_WIDTH
- LANE_WIDTH, 2, bits transferred per beat on m_lane
- NUM_MASTERS, 2, number of addressable masters (>=1)
- DEBOUNCE, 4, consecutive high samples required to recognise a button press (>=1)
- TIMEOUT, 16, WAIT_ACK cycles before error (>=1)
- SEL_WIDTH (derived), max(1, clog2(NUM_MASTERS))

Ports:

- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- switch  in  DATA_WIDTH  command word (write data or read address)
- btn_mode  in  1  level; 1 = write, 0 = read; sampled at load
- btn_load  in  1  load button
- btn_start  in  1  start button
- master_sel  in  SEL_WIDTH  target master; sampled at load
- m_ack  in  NUM_MASTERS  per-master command acknowledge
- m_rdata  in  NUM_MASTERS*DATA_WIDTH  per-master read return; master i at [i*DATA_WIDTH +: DATA_WIDTH]
- m_valid  out  NUM_MASTERS  one-hot beat strobe to the selected master
- m_rw  out  1  command direction, valid while any m_valid is high
- m_lane  out  LANE_WIDTH  shared serial data lane, qualified by m_valid
- rdata  out  DATA_WIDTH  last successfully read word
- loaded, busy, done, err  out  1 each  status

## Operation

- Button conditioning, per button:
  - A saturating counter counts consecutive high samples and clears on a low sample.
  - A one-cycle press event fires when the count reaches DEBOUNCE.
  - No further event fires until the button is sampled low.
- States: IDLE, LOADED, SHIFT, WAIT_ACK, DONE.
- IDLE/LOADED on a load event:
  - If master_sel < NUM_MASTERS: capture switch into the shift register, btn_mode into rw, master_sel into sel; set loaded=1 and err=0; go to LOADED.
  - Otherwise: set err=1, leave loaded unchanged, stay in the current state.
  - A reload in LOADED overwrites the captured values.
- LOADED on a start event: go to SHIFT, busy=1, loaded=0. A start event in IDLE is ignored.
- SHIFT lasts BEATS = DATA_WIDTH/LANE_WIDTH cycles:
  - m_valid[sel]=1 and m_rw=rw on every beat.
  - m_lane carries the top LANE_WIDTH bits of the shift register, MSB first; the register shifts left each beat.
  - After the last beat, go to WAIT_ACK.
- WAIT_ACK: m_valid=0.
  - m_ack[sel] high: if rw=0, rdata <= m_rdata slice for sel; err=0; go to DONE.
  - No ack for TIMEOUT cycles: err=1, go to DONE, rdata unchanged.
  - An ack on the TIMEOUT-th cycle counts as success.
  - Acks from other masters are ignored. Acks outside WAIT_ACK are ignored.
- DONE: done=1 for one cycle, busy=0, return to IDLE. err holds until the next valid load.
- Button events in SHIFT, WAIT_ACK and DONE are discarded. Debounce counters keep running.
- Simultaneous load and start events in LOADED: load wins; start is dropped.

## Timing

- Reset: all outputs 0 (m_valid, m_rw, m_lane, rdata, loaded, busy, done, err). State IDLE, debounce counters 0.
- Reset mid-operation aborts on that edge: m_valid is low the next cycle and the captured command is lost.
- Press latency: button sampled high on edges 1..DEBOUNCE; the event is consumed on edge DEBOUNCE+1.
- Start latency: on the start-consuming edge the FSM enters SHIFT, so m_valid is high in the following cycle. With default parameters, m_valid first rises 5 cycles after btn_start goes high.
- Command length: BEATS cycles of m_valid, contiguous, no gaps.
- Ack latency: done rises the cycle after the edge that samples m_ack. rdata and err update on that same edge.
- Full transaction with immediate ack: 1 (start) + BEATS + 1 (ack) + 1 (done) cycles.
- All outputs are registered.

## Test plan

- Write, defaults: sel=0, mode=1, switch=0xAA, load then start; ack on 3rd WAIT_ACK cycle -> m_valid[0] high 4 cycles, m_rw=1, m_lane 10,10,10,10; done pulse; err=0; rdata stays 0.
- Read: sel=1, mode=0, switch=0x62; m_rdata[15:8]=0x5C; ack on 1st WAIT_ACK cycle -> m_valid[1] 4 cycles, m_lane 01,10,00,10, m_rw=0; rdata=0x5C; done=1 for one cycle.
- Timeout: write to master 0, m_ack held 0 -> done after exactly 16 WAIT_ACK cycles, err=1. Ack on cycle 16 in a repeat run -> err=0.
- Debounce: btn_load high 3 cycles, low, then high 4 cycles -> only the second press loads; holding high 20 cycles produces one event.
- Invalid select, NUM_MASTERS=3: master_sel=3 at load -> err=1, loaded=0, start ignored, no m_valid. Next load with sel=2 clears err.
- Reset mid-SHIFT: reset on beat 2 -> next cycle all outputs 0, state IDLE. A fresh load/start completes normally.

Source files
------------

// File: rtl/cmd_processor_nm.sv
// cmd_processor_nm: debounced load/start buttons drive serial commands to one of N bus masters with ack/timeout handling
module cmd_processor_nm #(
    parameter int DATA_WIDTH = 8,
    parameter int LANE_WIDTH = 2,
    parameter int NUM_MASTERS = 2,
    parameter int DEBOUNCE = 4,
    parameter int TIMEOUT = 16,
    localparam int SEL_WIDTH = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [DATA_WIDTH-1:0]             switch,
    input  logic                              btn_mode,
    input  logic                              btn_load,
    input  logic                              btn_start,
    input  logic [SEL_WIDTH-1:0]              master_sel,
    input  logic [NUM_MASTERS-1:0]            m_ack,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
    output logic [NUM_MASTERS-1:0]            m_valid,
    output logic                              m_rw,
    output logic [LANE_WIDTH-1:0]             m_lane,
    output logic [DATA_WIDTH-1:0]             rdata,
    output logic                              loaded,
    output logic                              busy,
    output logic                              done,
    output logic                              err
);
  localparam int BEATS = DATA_WIDTH / LANE_WIDTH;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int DW = $clog2(DEBOUNCE + 2);
  localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
  localparam logic [TW-1:0] LAST_TICK = TW'(TIMEOUT - 1);
  localparam logic [SEL_WIDTH:0] SEL_LIMIT = (SEL_WIDTH + 1)'(NUM_MASTERS);
  localparam logic [DW-1:0] PRESS = DW'(DEBOUNCE);
  localparam logic [DW-1:0] HELD = DW'(DEBOUNCE + 1);
  typedef enum logic [2:0] {IDLE, LOADED, SHIFT, WAIT_ACK, DONE} state_t;
  state_t state;
  logic [1:0] btn;
  logic [1:0] press;
  logic [DATA_WIDTH-1:0] shreg;
  logic rw;
  logic [SEL_WIDTH-1:0] sel;
  logic [BW-1:0] beat;
  logic [TW-1:0] tmr;
  logic sel_ok;
  assign btn = {btn_start, btn_load};
  assign sel_ok = {1'b0, master_sel} < SEL_LIMIT;
  genvar i;
  for (i = 0; i < 2; i++) begin : g_db
    logic [DW-1:0] cnt;
    always_ff @(posedge clk)
      if (reset) cnt <= '0;
      else cnt <= !btn[i] ? '0 : cnt == HELD ? HELD : cnt + 1'b1;
    assign press[i] = cnt == PRESS;
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      rw <= 1'b0;
      sel <= '0;
      beat <= '0;
      tmr <= '0;
      m_valid <= '0;
      m_rw <= 1'b0;
      m_lane <= '0;
      rdata <= '0;
      loaded <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err <= 1'b0;
    end else
      case (state)
        IDLE, LOADED:
          if (press[0]) begin
            if (sel_ok) begin
              shreg <= switch;
              rw <= btn_mode;
              sel <= master_sel;
              loaded <= 1'b1;
              err <= 1'b0;
              state <= LOADED;
            end else err <= 1'b1;
          end else if (press[1] && state == LOADED) begin
            state <= SHIFT;
            busy <= 1'b1;
            loaded <= 1'b0;
            beat <= '0;
            m_valid <= NUM_MASTERS'(1) << sel;
            m_rw <= rw;
            m_lane <= shreg[DATA_WIDTH-1 -: LANE_WIDTH];
            shreg <= shreg << LANE_WIDTH;
          end
        SHIFT:
          if (beat == LAST_BEAT) begin
            m_valid <= '0;
            m_rw <= 1'b0;
            m_lane <= '0;
            tmr <= '0;
            state <= WAIT_ACK;
          end else begin
            beat <= beat + 1'b1;
            m_lane <= shreg[DATA_WIDTH-1 -: LANE_WIDTH];
            shreg <= shreg << LANE_WIDTH;
          end
        WAIT_ACK:
          if (m_ack[sel]) begin
            if (!rw) rdata <= m_rdata[sel*DATA_WIDTH +: DATA_WIDTH];
            err <= 1'b0;
            done <= 1'b1;
            busy <= 1'b0;
            state <= DONE;
          end else if (tmr == LAST_TICK) begin
            err <= 1'b1;
            done <= 1'b1;
            busy <= 1'b0;
            state <= DONE;
          end else tmr <= tmr + 1'b1;
        DONE: begin
          done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
endmodule
